// File: rtl/timer_countdown_ctrl.sv
// Countdown timer sequencer: owns MIN:SEC and the IDLE/SET/RUN/PAUSE/ALARM state.
// Optional macro TIMER_PRESET_EN adds a preset register reloaded on clear/expiry.
module timer_countdown_ctrl #(
    parameter int MAX_MIN   = 59,
    parameter int ALARM_SEC = 10
) (
    input  logic       CLK,
    input  logic       RESETN,
    input  logic       TICK_1HZ,
    input  logic       SW_T_EN,
    input  logic       SW_SET,
    input  logic       SW_UP_MIN,
    input  logic       SW_UP_SEC,
    input  logic       SW_CLR,
    output logic [6:0] MIN,
    output logic [5:0] SEC,
    output logic [2:0] STATE,
    output logic       TIMER_RUN,
    output logic       ALARM
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SET   = 3'd1,
        S_RUN   = 3'd2,
        S_PAUSE = 3'd3,
        S_ALARM = 3'd4
    } state_t;

    localparam int                CNT_W      = (ALARM_SEC < 2) ? 1 : $clog2(ALARM_SEC + 1);
    localparam logic [CNT_W-1:0]  ALARM_LAST = CNT_W'(ALARM_SEC - 1);
    localparam logic [6:0]        MAX_MIN_V  = 7'(MAX_MIN);

    state_t           state;
    logic [CNT_W-1:0] alarm_cnt;

    logic       time_nz;
    logic [6:0] dec_min;
    logic [5:0] dec_sec;
    logic       dec_zero;
    logic [6:0] inc_min;
    logic [5:0] inc_sec;
    logic [6:0] rld_min;
    logic [5:0] rld_sec;

    assign STATE   = state;
    assign time_nz = (MIN != 7'd0) || (SEC != 6'd0);
    assign inc_min = (MIN == MAX_MIN_V) ? 7'd0 : MIN + 7'd1;
    assign inc_sec = (SEC == 6'd59) ? 6'd0 : SEC + 6'd1;

    always_comb begin
        dec_min = MIN;
        dec_sec = SEC;
        if (SEC != 6'd0) begin
            dec_sec = SEC - 6'd1;
        end else if (MIN != 7'd0) begin
            dec_min = MIN - 7'd1;
            dec_sec = 6'd59;
        end
        dec_zero = (dec_min == 7'd0) && (dec_sec == 6'd0);
    end

`ifdef TIMER_PRESET_EN
    logic [6:0] preset_min;
    logic [5:0] preset_sec;

    // Capture exactly on the IDLE/SET -> RUN transitions of the main FSM
    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            preset_min <= 7'd0;
            preset_sec <= 6'd0;
        end else if ((state == S_IDLE || state == S_SET) && !SW_CLR && SW_T_EN && time_nz) begin
            preset_min <= MIN;
            preset_sec <= SEC;
        end
    end

    assign rld_min = preset_min;
    assign rld_sec = preset_sec;
`else
    assign rld_min = 7'd0;
    assign rld_sec = 6'd0;
`endif

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state     <= S_IDLE;
            MIN       <= 7'd0;
            SEC       <= 6'd0;
            TIMER_RUN <= 1'b0;
            ALARM     <= 1'b0;
            alarm_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (SW_CLR) begin
                        MIN <= 7'd0;
                        SEC <= 6'd0;
                    end else if (SW_T_EN) begin
                        if (time_nz) begin
                            state     <= S_RUN;
                            TIMER_RUN <= 1'b1;
                        end
                    end else if (SW_SET) begin
                        state <= S_SET;
                    end
                end
                S_SET: begin
                    if (SW_CLR) begin
                        MIN <= 7'd0;
                        SEC <= 6'd0;
                    end else if (SW_T_EN) begin
                        if (time_nz) begin
                            state     <= S_RUN;
                            TIMER_RUN <= 1'b1;
                        end else begin
                            state <= S_IDLE;
                        end
                    end else if (SW_SET) begin
                        state <= S_IDLE;
                    end else begin
                        if (SW_UP_MIN) MIN <= inc_min;
                        if (SW_UP_SEC) SEC <= inc_sec;
                    end
                end
                S_RUN: begin
                    if (SW_CLR) begin
                        state     <= S_IDLE;
                        TIMER_RUN <= 1'b0;
                        MIN       <= rld_min;
                        SEC       <= rld_sec;
                    end else if (SW_T_EN) begin
                        state     <= S_PAUSE;
                        TIMER_RUN <= 1'b0;
                    end else if (TICK_1HZ) begin
                        MIN <= dec_min;
                        SEC <= dec_sec;
                        // Expiry enters ALARM on the same edge that reaches 00:00
                        if (dec_zero) begin
                            state     <= S_ALARM;
                            TIMER_RUN <= 1'b0;
                            ALARM     <= 1'b1;
                            alarm_cnt <= '0;
                        end
                    end
                end
                S_PAUSE: begin
                    if (SW_CLR) begin
                        state <= S_IDLE;
                        MIN   <= rld_min;
                        SEC   <= rld_sec;
                    end else if (SW_T_EN) begin
                        state     <= S_RUN;
                        TIMER_RUN <= 1'b1;
                    end
                end
                S_ALARM: begin
                    if (SW_CLR) begin
                        state <= S_IDLE;
                        ALARM <= 1'b0;
                        MIN   <= rld_min;
                        SEC   <= rld_sec;
                    end else if (SW_T_EN) begin
                        state <= S_IDLE;
                        ALARM <= 1'b0;
                    end else if (TICK_1HZ) begin
                        if (alarm_cnt == ALARM_LAST) begin
                            state     <= S_IDLE;
                            ALARM     <= 1'b0;
                            alarm_cnt <= '0;
                            MIN       <= rld_min;
                            SEC       <= rld_sec;
                        end else begin
                            alarm_cnt <= alarm_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= S_IDLE;
                    TIMER_RUN <= 1'b0;
                    ALARM     <= 1'b0;
                    alarm_cnt <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_timer_countdown_ctrl.sv
// Bench for timer_countdown_ctrl: directed test-plan sequences plus random pulses
// checked every cycle against a total-seconds reference model.
module tb_timer_countdown_ctrl;

    localparam int MAX_MIN   = 59;
    localparam int ALARM_SEC = 10;

    logic       CLK;
    logic       RESETN;
    logic       TICK_1HZ, SW_T_EN, SW_SET, SW_UP_MIN, SW_UP_SEC, SW_CLR;
    logic [6:0] MIN;
    logic [5:0] SEC;
    logic [2:0] STATE;
    logic       TIMER_RUN, ALARM;

    timer_countdown_ctrl #(.MAX_MIN(MAX_MIN), .ALARM_SEC(ALARM_SEC)) dut (
        .CLK(CLK), .RESETN(RESETN), .TICK_1HZ(TICK_1HZ), .SW_T_EN(SW_T_EN),
        .SW_SET(SW_SET), .SW_UP_MIN(SW_UP_MIN), .SW_UP_SEC(SW_UP_SEC), .SW_CLR(SW_CLR),
        .MIN(MIN), .SEC(SEC), .STATE(STATE), .TIMER_RUN(TIMER_RUN), .ALARM(ALARM)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: state as 0..4, time as separate minute/second numbers
    int m_min, m_sec, m_st, m_cnt, p_min, p_sec;

    task automatic check(input string tag, input int obs, input int exp);
        n_tests++;
        if (obs != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reload();
`ifdef TIMER_PRESET_EN
        m_min = p_min;
        m_sec = p_sec;
`else
        m_min = 0;
        m_sec = 0;
`endif
    endtask

    task automatic model_start();
        p_min = m_min;
        p_sec = m_sec;
        m_st  = 2;
    endtask

    task automatic model_step(input bit clr, ten, set, um, us, tick);
        int t;
        t = m_min * 60 + m_sec;
        case (m_st)
            0: begin
                if (clr) begin m_min = 0; m_sec = 0; end
                else if (ten) begin if (t > 0) model_start(); end
                else if (set) m_st = 1;
            end
            1: begin
                if (clr) begin m_min = 0; m_sec = 0; end
                else if (ten) begin if (t > 0) model_start(); else m_st = 0; end
                else if (set) m_st = 0;
                else begin
                    if (um) m_min = (m_min + 1) % (MAX_MIN + 1);
                    if (us) m_sec = (m_sec + 1) % 60;
                end
            end
            2: begin
                if (clr) begin m_st = 0; model_reload(); end
                else if (ten) m_st = 3;
                else if (tick) begin
                    if (t > 0) t = t - 1;
                    m_min = t / 60;
                    m_sec = t % 60;
                    if (t == 0) begin m_st = 4; m_cnt = 0; end
                end
            end
            3: begin
                if (clr) begin m_st = 0; model_reload(); end
                else if (ten) m_st = 2;
            end
            4: begin
                if (clr) begin m_st = 0; model_reload(); end
                else if (ten) m_st = 0;
                else if (tick) begin
                    m_cnt++;
                    if (m_cnt >= ALARM_SEC) begin m_st = 0; model_reload(); end
                end
            end
            default: m_st = 0;
        endcase
    endtask

    task automatic compare_all(input string tag);
        check({tag, "_min"},   int'(MIN),       m_min);
        check({tag, "_sec"},   int'(SEC),       m_sec);
        check({tag, "_state"}, int'(STATE),     m_st);
        check({tag, "_run"},   int'(TIMER_RUN), int'(m_st == 2));
        check({tag, "_alarm"}, int'(ALARM),     int'(m_st == 4));
    endtask

    // Inputs change 1 time unit after a rising edge; outputs are checked there too
    task automatic step(input bit clr, ten, set, um, us, tick);
        SW_CLR = clr; SW_T_EN = ten; SW_SET = set;
        SW_UP_MIN = um; SW_UP_SEC = us; TICK_1HZ = tick;
        @(posedge CLK);
        model_step(clr, ten, set, um, us, tick);
        #1;
        SW_CLR = 0; SW_T_EN = 0; SW_SET = 0;
        SW_UP_MIN = 0; SW_UP_SEC = 0; TICK_1HZ = 0;
        compare_all("step");
    endtask

    task automatic do_reset();
        RESETN = 1'b0;
        #2;
        m_min = 0; m_sec = 0; m_st = 0; m_cnt = 0; p_min = 0; p_sec = 0;
        compare_all("rst");
        @(posedge CLK);
        #1;
        RESETN = 1'b1;
    endtask

    task automatic tick();        step(0, 0, 0, 0, 0, 1); endtask
    task automatic t_en();        step(0, 1, 0, 0, 0, 0); endtask

    task automatic load_time(input int mm, input int ss);
        do_reset();
        step(0, 0, 1, 0, 0, 0);
        repeat (mm) step(0, 0, 0, 1, 0, 0);
        repeat (ss) step(0, 0, 0, 0, 1, 0);
    endtask

    initial begin
        SW_CLR = 0; SW_T_EN = 0; SW_SET = 0; SW_UP_MIN = 0; SW_UP_SEC = 0; TICK_1HZ = 0;
        RESETN = 1'b0;
        #3;
        m_min = 0; m_sec = 0; m_st = 0; m_cnt = 0; p_min = 0; p_sec = 0;
        compare_all("por");
        @(posedge CLK);
        #1;
        RESETN = 1'b1;

        // Set 02:03 and start
        load_time(2, 3);
        t_en();
        check("t1_state", int'(STATE), 2);
        check("t1_run",   int'(TIMER_RUN), 1);
        check("t1_min",   int'(MIN), 2);
        check("t1_sec",   int'(SEC), 3);

        // 01:00 borrows into 00:59; 00:01 expires into ALARM on the same edge
        load_time(1, 0);
        t_en();
        tick();
        check("t2_min", int'(MIN), 0);
        check("t2_sec", int'(SEC), 59);
        load_time(0, 1);
        t_en();
        tick();
        check("t2_alarm_sec",   int'(SEC), 0);
        check("t2_alarm_state", int'(STATE), 4);
        check("t2_alarm_out",   int'(ALARM), 1);

        // Alarm holds for ALARM_SEC ticks, then auto-returns to IDLE
        repeat (ALARM_SEC - 1) tick();
        check("t3_alarm_held", int'(ALARM), 1);
        tick();
        check("t3_alarm_done", int'(ALARM), 0);
        check("t3_idle",       int'(STATE), 0);
        load_time(0, 1);
        t_en();
        tick();
        repeat (3) tick();
        t_en();
        check("t3_abort_state", int'(STATE), 0);
        check("t3_abort_alarm", int'(ALARM), 0);

        // Pause wins over a coincident tick and freezes time
        load_time(0, 30);
        t_en();
        step(0, 1, 0, 0, 0, 1);
        check("t4_pause", int'(STATE), 3);
        check("t4_sec",   int'(SEC), 30);
        repeat (5) tick();
        check("t4_frozen", int'(SEC), 30);
        t_en();
        check("t4_resume", int'(STATE), 2);
        tick();
        check("t4_count", int'(SEC), 29);

        // Wrap boundaries in SET, then a zero-time start stays IDLE
        load_time(1, 59);
        step(0, 0, 0, 0, 1, 0);
        check("t5_sec_wrap", int'(SEC), 0);
        check("t5_min_kept", int'(MIN), 1);
        repeat (MAX_MIN - 1) step(0, 0, 0, 1, 0, 0);
        check("t5_min_max", int'(MIN), MAX_MIN);
        step(0, 0, 0, 1, 0, 0);
        check("t5_min_wrap", int'(MIN), 0);
        step(0, 0, 1, 0, 0, 0);
        t_en();
        check("t5_zero_start", int'(STATE), 0);
        step(0, 0, 1, 0, 1, 0);
        check("t5_set_beats_up", int'(STATE), 1);
        check("t5_set_up_drop",  int'(SEC), 0);

        // Asynchronous reset mid-run
        load_time(3, 15);
        t_en();
        tick();
        do_reset();
        check("t6_rst_state", int'(STATE), 0);
        check("t6_rst_min",   int'(MIN), 0);

`ifdef TIMER_PRESET_EN
        load_time(1, 30);
        t_en();
        repeat (5) tick();
        step(1, 0, 0, 0, 0, 0);
        check("t6_preset_state", int'(STATE), 0);
        check("t6_preset_min",   int'(MIN), 1);
        check("t6_preset_sec",   int'(SEC), 30);
`endif

        // Random pulse mix, every cycle compared with the model
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 49) == 0, $urandom_range(0, 11) == 0,
                     $urandom_range(0, 9) == 0,  $urandom_range(0, 3) == 0,
                     $urandom_range(0, 2) == 0,  $urandom_range(0, 2) == 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/timer_countdown_ctrl.md
Name: timer_countdown_ctrl

Overview:
Sequencer for the stopwatch/timer section of the clock. It owns the countdown minute/second registers and the run/pause/alarm state. SW_T_EN toggles between running and paused, and is the same start/stop semantics as the timer on/off flag. The block feeds the display mux and the buzzer driver, and advances on a 1 Hz tick from the shared prescaler.

Parameters:
MAX_MIN, 59, largest settable minute value; minutes wrap to 0 above it.
ALARM_SEC, 10, number of TICK_1HZ pulses the alarm stays asserted before auto-return to IDLE.

Ports:
CLK  input  1  system clock, all state updates on rising edge
RESETN  input  1  asynchronous active-low reset
TICK_1HZ  input  1  one-CLK-wide pulse once per second
SW_T_EN  input  1  one-cycle pulse: start/pause toggle
SW_SET  input  1  one-cycle pulse: enter/leave SET mode
SW_UP_MIN  input  1  one-cycle pulse: increment minutes (SET only)
SW_UP_SEC  input  1  one-cycle pulse: increment seconds (SET only)
SW_CLR  input  1  one-cycle pulse: clear/abort
MIN  output  7  remaining minutes, binary 0..MAX_MIN
SEC  output  6  remaining seconds, binary 0..59
STATE  output  3  IDLE=0 SET=1 RUN=2 PAUSE=3 ALARM=4
TIMER_RUN  output  1  high exactly when STATE==RUN
ALARM  output  1  high exactly when STATE==ALARM

Behaviour:
- Single clock, CLK. Reset is asynchronous and active-low on RESETN. All outputs are registered.
- Reset values: MIN=0, SEC=0, STATE=IDLE, TIMER_RUN=0, ALARM=0, internal alarm counter=0. Reset asserted mid-RUN or mid-ALARM clears everything immediately, without waiting for CLK.
- Switch inputs arrive already debounced and edge-detected (one-cycle pulses).
- Response latency: an input sampled on edge N is reflected on the outputs after edge N.
- Same-cycle priority: SW_CLR > SW_T_EN > SW_SET > SW_UP_MIN/SW_UP_SEC > TICK_1HZ. Lower-priority events in that cycle are dropped. SW_UP_MIN and SW_UP_SEC together apply both increments.
- IDLE:
  - SW_SET -> SET.
  - SW_T_EN with MIN:SEC != 00:00 -> RUN; with 00:00, stay IDLE.
  - SW_CLR -> MIN=SEC=0.
  - Ticks are ignored.
- SET:
  - SW_UP_MIN: MIN = (MIN==MAX_MIN) ? 0 : MIN+1.
  - SW_UP_SEC: SEC = (SEC==59) ? 0 : SEC+1. No carry into MIN.
  - SW_CLR: MIN=SEC=0, stay SET.
  - SW_SET -> IDLE.
  - SW_T_EN: nonzero time -> RUN; zero time -> IDLE.
- RUN, on TICK_1HZ:
  - If SEC>0: SEC-1.
  - Else if MIN>0: MIN-1 and SEC=59.
  - If the new value is 00:00, STATE -> ALARM on the same edge and the alarm counter loads 0.
  - SW_T_EN -> PAUSE; a coincident tick is ignored.
  - SW_CLR -> IDLE with MIN=SEC=0.
- PAUSE:
  - Time is frozen and ticks are ignored.
  - SW_T_EN -> RUN.
  - SW_CLR -> IDLE with MIN=SEC=0.
  - SW_SET is ignored.
- ALARM:
  - Each TICK_1HZ increments the alarm counter. When it reaches ALARM_SEC -> IDLE.
  - SW_T_EN or SW_CLR -> IDLE immediately.
  - MIN=SEC=0 throughout.
- UP pulses outside SET are ignored. Illegal STATE encodings (5..7) return to IDLE on the next edge.

Optional Feature:
TIMER_PRESET_EN:
- When defined, a preset register (7+6 bits, reset 00:00) captures MIN:SEC on every transition from IDLE or SET into RUN.
- SW_CLR in RUN, PAUSE or ALARM then goes to IDLE with MIN:SEC reloaded from the preset instead of 00:00.
- SW_CLR in IDLE and SET still clears to 00:00.
- Auto-expiry of ALARM also reloads the preset.
- When not defined, there is no preset register and all clears and expiries give 00:00.

Test Plan:
1. Reset, SET, SW_UP_MIN x2, SW_UP_SEC x3, SW_T_EN -> STATE=RUN, TIMER_RUN=1, MIN=2, SEC=3.
2. Start from 01:00 in RUN, one TICK -> 00:59. Load 00:01 then TICK -> SEC=0, STATE=ALARM, ALARM=1 on the same edge.
3. In ALARM, 10 ticks with ALARM_SEC=10 -> ALARM falls after the 10th tick, STATE=IDLE. Repeat, pulsing SW_T_EN after 3 ticks -> IDLE immediately.
4. In RUN at 00:30, SW_T_EN and TICK in the same cycle -> PAUSE, SEC stays 30. Five ticks -> still 30. SW_T_EN -> RUN.
5. In SET, SW_UP_SEC from SEC=59 -> SEC=0, MIN unchanged. SW_UP_MIN from MIN=59 -> 0. IDLE with 00:00, SW_T_EN -> stays IDLE.
6. RESETN low mid-RUN at 03:15 -> all outputs 0 asynchronously. With TIMER_PRESET_EN: start 01:30, run 5 ticks, SW_CLR -> IDLE at 01:30.
